fe_pc_sequencer: RTL
====================

Name: fe_pc_sequencer

Overview:
- Owns the fetch PC and decides each cycle whether the front end advances, holds, redirects or halts.
- Arbitrates between four requesters: DE stall, AGEX branch redirect, WB trap redirect and WB halt.
- Drives the fetch PC, PC+INSTSIZE, a fetch-valid strobe and a one-cycle flush pulse for the FE/DE latches.
- Keeps instruction and redirect counters for debug.

Parameters:
- DBITS, 32, width of PC, targets and counters.
- INSTSIZE, 4, PC increment in bytes; power of two.
- STARTPC, 32'h100, PC value loaded on reset.
- REDIRECT_BUBBLES, 1, dead fetch cycles after an accepted redirect; legal range 0..7.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- de_stall  in  1  DE requests the front end to hold.
- agex_br_valid  in  1  branch/jump redirect request from AGEX.
- agex_br_target  in  DBITS  redirect target from AGEX.
- wb_trap_valid  in  1  trap redirect request from WB.
- wb_trap_target  in  DBITS  trap target from WB.
- wb_halt  in  1  halt request from WB.
- pc_out  out  DBITS  current fetch PC, registered.
- pc_plus_out  out  DBITS  pc_out+INSTSIZE, combinational, modulo 2^DBITS.
- fetch_valid  out  1  the fetch at pc_out is valid and is latched this cycle.
- fe_flush  out  1  registered pulse; invalidates FE/DE latch contents.
- inst_count  out  DBITS  count of advanced fetches, starting at 1.
- redirect_count  out  DBITS  count of accepted redirects, saturating.
- misalign_err  out  1  sticky flag: a redirect target was misaligned.
- state_out  out  2  RUN=0, STALL=1, BUBBLE=2, HALT=3.

Behaviour:
- Reset values: pc_out=STARTPC, inst_count=1, redirect_count=0, fe_flush=0, misalign_err=0, state=RUN, bubble counter=0.
- Reset asserted mid-operation, in any state, returns all registers to these values immediately.
- fetch_valid is combinational: (state==RUN or state==STALL) and !de_stall. It is 0 in BUBBLE and HALT.
- Event priority, evaluated at every posedge outside HALT, highest first: wb_halt > wb_trap_valid > agex_br_valid > de_stall > advance.
- Halt: state<=HALT; pc_out is held.
  - HALT is terminal until reset; all requests are ignored.
  - fe_flush<=0.
- Trap or branch redirect:
  - pc_out<=target with bits [log2(INSTSIZE)-1:0] forced to 0. If any of those bits were set, misalign_err<=1 (sticky).
  - fe_flush<=1 for exactly one cycle.
  - redirect_count increments and saturates at all-ones.
  - inst_count is unchanged.
  - If REDIRECT_BUBBLES>0: state<=BUBBLE and bubble counter<=REDIRECT_BUBBLES. Otherwise state<=RUN.
- Simultaneous trap and branch: the trap wins and the branch is dropped; it counts as one redirect.
- A redirect overrides de_stall, because the stalled younger instructions are being flushed.
- Stall, with no redirect and de_stall=1: pc_out held, state<=STALL, fe_flush<=0.
- Advance, with fetch_valid=1 and no higher event:
  - pc_out<=pc_out+INSTSIZE, wrapping modulo 2^DBITS.
  - inst_count increments, wrapping.
  - state<=RUN, fe_flush<=0.
- BUBBLE:
  - pc_out held; the counter decrements each cycle.
  - When the counter reaches 1 at an edge, the next state is STALL if de_stall=1, else RUN.
  - A new redirect during BUBBLE is accepted: new target, counter reloads, new flush pulse.
  - wb_halt during BUBBLE goes to HALT.
- fe_flush is asserted only in the cycle immediately after an accepted redirect.
- Latency: a redirect target appears on pc_out one cycle after the request edge. The first valid fetch at that target occurs REDIRECT_BUBBLES cycles later.

Test Plan:
- Release reset with no requests and run 4 cycles -> pc_out 0x100, 0x104, 0x108, 0x10C; inst_count 1..4; fetch_valid=1 throughout.
- Hold de_stall for 3 cycles at pc 0x108 -> pc_out stays 0x108, state=STALL, fetch_valid=0, inst_count frozen. After release, pc_out=0x10C next cycle.
- Pulse agex_br_valid with target 0x200, REDIRECT_BUBBLES=1:
  - next cycle: pc_out=0x200, fe_flush=1, state=BUBBLE, fetch_valid=0, redirect_count=1.
  - following cycle: state=RUN and fetch_valid=1.
  - next pc_out=0x204.
- Assert wb_trap_valid (target 0x40) and agex_br_valid (target 0x300) in the same cycle while de_stall=1 -> pc_out=0x40, one flush pulse, redirect_count increments by 1.
- Branch to target 0x203 -> pc_out=0x200 and misalign_err=1. misalign_err remains 1 after a later aligned branch to 0x400.
- Assert wb_halt during BUBBLE, then pulse agex_br_valid -> state=HALT, pc_out frozen, redirect_count unchanged.
  - Then assert reset asynchronously mid-cycle -> pc_out=0x100 and state=RUN immediately.
- Set pc to 0xFFFFFFFC via a branch, then advance -> pc_out wraps to 0x00000000.

Source files
------------

// File: rtl/fe_pc_sequencer.sv
// Front-end PC sequencer: owns the fetch PC and arbitrates stall, branch/trap
// redirect and halt requests, with redirect bubbles and debug counters.
module fe_pc_sequencer #(
  parameter int unsigned     DBITS            = 32,
  parameter int unsigned     INSTSIZE         = 4,
  parameter logic [DBITS-1:0] STARTPC         = DBITS'(32'h100),
  parameter int unsigned     REDIRECT_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de_stall,
  input  logic             agex_br_valid,
  input  logic [DBITS-1:0] agex_br_target,
  input  logic             wb_trap_valid,
  input  logic [DBITS-1:0] wb_trap_target,
  input  logic             wb_halt,
  output logic [DBITS-1:0] pc_out,
  output logic [DBITS-1:0] pc_plus_out,
  output logic             fetch_valid,
  output logic             fe_flush,
  output logic [DBITS-1:0] inst_count,
  output logic [DBITS-1:0] redirect_count,
  output logic             misalign_err,
  output logic [1:0]       state_out
);

  localparam int unsigned BUB_W = 3;
  localparam logic [DBITS-1:0] OFF_MASK = DBITS'(INSTSIZE - 1);
  localparam logic [DBITS-1:0] INC      = DBITS'(INSTSIZE);
  localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(REDIRECT_BUBBLES);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STALL  = 2'd1,
    S_BUBBLE = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DBITS-1:0] pc_q, pc_d;
  logic [DBITS-1:0] inst_q, inst_d;
  logic [DBITS-1:0] redir_q, redir_d;
  logic             flush_q, flush_d;
  logic             mis_q, mis_d;
  logic [BUB_W-1:0] bub_q, bub_d;

  logic             redirect_req;
  logic [DBITS-1:0] redirect_tgt;

  // Trap beats branch when both arrive together; only one redirect is taken.
  assign redirect_req = wb_trap_valid | agex_br_valid;
  assign redirect_tgt = wb_trap_valid ? wb_trap_target : agex_br_target;

  // Next-state and register update decisions
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    redir_d = redir_q;
    flush_d = 1'b0;
    mis_d   = mis_q;
    bub_d   = bub_q;
    case (state_q)
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        if (wb_halt) begin
          state_d = S_HALT;
        end else if (redirect_req) begin
          pc_d    = redirect_tgt & ~OFF_MASK;
          mis_d   = mis_q | (|(redirect_tgt & OFF_MASK));
          flush_d = 1'b1;
          redir_d = (redir_q == '1) ? redir_q : redir_q + DBITS'(1);
          if (REDIRECT_BUBBLES > 0) begin
            state_d = S_BUBBLE;
            bub_d   = BUB_INIT;
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_BUBBLE) begin
          bub_d = bub_q - BUB_W'(1);
          if (bub_q <= BUB_W'(1)) begin
            state_d = de_stall ? S_STALL : S_RUN;
          end
        end else if (de_stall) begin
          state_d = S_STALL;
        end else begin
          pc_d    = pc_q + INC;
          inst_d  = inst_q + DBITS'(1);
          state_d = S_RUN;
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= STARTPC;
      inst_q  <= DBITS'(1);
      redir_q <= '0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      redir_q <= redir_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
      bub_q   <= bub_d;
    end
  end

  assign pc_out         = pc_q;
  assign pc_plus_out    = pc_q + INC;
  assign fetch_valid    = ((state_q == S_RUN) || (state_q == S_STALL)) && !de_stall;
  assign fe_flush       = flush_q;
  assign inst_count     = inst_q;
  assign redirect_count = redir_q;
  assign misalign_err   = mis_q;
  assign state_out      = state_q;

endmodule
